// File: rtl/instr_decoder_pkg.sv
// Shared opcode, field-position and FSM-state definitions for the control-flow decoder.
package instr_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_JMP  = 4'h1,
    OP_JZ   = 4'h2,
    OP_JNZ  = 4'h3,
    OP_CALL = 4'h4,
    OP_RET  = 4'h5,
    OP_WAIT = 4'h6,
    OP_HALT = 4'h7
  } opcode_e;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int ARG_MSB   = 11;
  localparam int ARG_LSB   = 0;
  localparam int WAIT_BITS = 8;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAITING = 2'd1,
    HALT    = 2'd2
  } dec_state_e;

endpackage

// File: rtl/instr_decoder_return_stack.sv
// Parameterised LIFO holding return addresses; illegal push (full) or pop (empty) is ignored.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      count;
  logic [PW-1:0]    top;

  // When full the low bits wrap to 0, so top lands on DEPTH-1 as required.
  assign top   = count[PW-1:0] - PW'(1);
  assign dout  = mem[top];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (push && !full) begin
      mem[count[PW-1:0]] <= din;
      count              <= count + (PW+1)'(1);
    end else if (pop && !empty) begin
      count <= count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/instr_decoder.sv
// Zero-latency control-flow decoder: jumps, branches, call/return, timed wait, halt, EXEC forwarding.
module instr_decoder
  import instr_pkg::*;
#(
  parameter int BITS_FOR_INSTRUCTIONS = 5,
  parameter int INSTR_WIDTH           = 16,
  parameter int STACK_DEPTH           = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BITS_FOR_INSTRUCTIONS-1:0] pc_address,
  input  logic [INSTR_WIDTH-1:0]           instr_word,
  input  logic                             cond_zero,
  output logic                             jump_enable,
  output logic [BITS_FOR_INSTRUCTIONS-1:0] jump_value,
  output logic                             exec_valid,
  output logic [INSTR_WIDTH-1:0]           exec_word,
  output logic                             halted,
  output logic                             fault
);

  localparam int B = BITS_FOR_INSTRUCTIONS;

  dec_state_e           state, state_nxt;
  logic [WAIT_BITS-1:0] wait_cnt, wait_nxt, wait_n;
  logic                 fault_q, fault_set;
  logic                 jen, ev, push, pop;
  logic [B-1:0]         jval, target, ret_addr, pc_inc;
  logic                 full, empty;
  opcode_e              op;

  assign op     = opcode_e'(instr_word[OP_MSB:OP_LSB]);
  assign target = instr_word[B-1:0];
  assign wait_n = instr_word[WAIT_BITS-1:0];
  assign pc_inc = pc_address + B'(1);

  return_stack #(.DEPTH(STACK_DEPTH), .WIDTH(B)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ret_addr),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    jen       = 1'b0;
    jval      = '0;
    ev        = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    fault_set = 1'b0;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RUN: begin
        case (op)
          OP_NOP: ;
          OP_JMP: begin jen = 1'b1; jval = target; end
          OP_JZ:  if (cond_zero)  begin jen = 1'b1; jval = target; end
          OP_JNZ: if (!cond_zero) begin jen = 1'b1; jval = target; end
          OP_CALL: begin
            if (full) fault_set = 1'b1;
            else begin push = 1'b1; jen = 1'b1; jval = target; end
          end
          OP_RET: begin
            if (empty) fault_set = 1'b1;
            else begin pop = 1'b1; jen = 1'b1; jval = ret_addr; end
          end
          OP_WAIT: begin
            if (wait_n != '0) begin
              jen       = 1'b1;
              jval      = pc_address;
              wait_nxt  = wait_n;
              state_nxt = WAITING;
            end
          end
          OP_HALT: begin
            jen       = 1'b1;
            jval      = pc_address;
            state_nxt = HALT;
          end
          default: ev = 1'b1;
        endcase
      end
      // The word at the held address is ignored while counting down.
      WAITING: begin
        if (wait_cnt > WAIT_BITS'(1)) begin
          jen      = 1'b1;
          jval     = pc_address;
          wait_nxt = wait_cnt - WAIT_BITS'(1);
        end else begin
          wait_nxt  = '0;
          state_nxt = RUN;
        end
      end
      HALT: begin
        jen  = 1'b1;
        jval = pc_address;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (fault_set) fault_q <= 1'b1;
    end
  end

  // Gated with rst so every output reads 0 for the whole time reset is held.
  assign jump_enable = rst & jen;
  assign jump_value  = rst ? jval : '0;
  assign exec_valid  = rst & ev;
  assign exec_word   = (rst && ev) ? instr_word : '0;
  assign halted      = rst & (state == HALT);
  assign fault       = rst & fault_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder: single-cycle vector table plus hand-written multi-cycle sequences.
module tb_instr_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  pc_address = '0;
  logic [15:0] instr_word = '0;
  logic        cond_zero  = 1'b0;
  logic        jump_enable;
  logic [4:0]  jump_value;
  logic        exec_valid;
  logic [15:0] exec_word;
  logic        halted;
  logic        fault;

  int n_total = 0;
  int n_pass  = 0;

  instr_decoder #(
    .BITS_FOR_INSTRUCTIONS(5),
    .INSTR_WIDTH(16),
    .STACK_DEPTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_address  (pc_address),
    .instr_word  (instr_word),
    .cond_zero   (cond_zero),
    .jump_enable (jump_enable),
    .jump_value  (jump_value),
    .exec_valid  (exec_valid),
    .exec_word   (exec_word),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] word;
    logic [4:0]  pc;
    logic        cz;
    logic        jen;
    logic [4:0]  jval;
    logic        ev;
    logic [15:0] ew;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one decode cycle just after the rising edge; outputs are settled when it returns.
  task automatic apply(input logic r, input logic [15:0] w, input logic [4:0] pc, input logic cz);
    @(posedge clk);
    #1;
    rst = r; instr_word = w; pc_address = pc; cond_zero = cz;
    #3;
  endtask

  task automatic chk_jump(input string name, input logic jen, input logic [4:0] jval);
    chk({name, ".jen"},  32'(jump_enable), 32'(jen));
    chk({name, ".jval"}, 32'(jump_value),  32'(jval));
  endtask

  task automatic chk_all_zero(input string name);
    chk_jump(name, 1'b0, 5'd0);
    chk({name, ".ev"},     32'(exec_valid), 32'd0);
    chk({name, ".ew"},     32'(exec_word),  32'd0);
    chk({name, ".halted"}, 32'(halted),     32'd0);
    chk({name, ".fault"},  32'(fault),      32'd0);
  endtask

  task automatic do_reset();
    apply(1'b0, 16'h0000, 5'd0, 1'b0);
  endtask

  initial begin
    vt[0]  = '{"nop",       16'h0000, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 16'h0000};
    vt[1]  = '{"jmp0c",     16'h100C, 5'd1,  1'b0, 1'b1, 5'd12, 1'b0, 16'h0000};
    vt[2]  = '{"jmp_upper", 16'h1FEC, 5'd2,  1'b0, 1'b1, 5'd12, 1'b0, 16'h0000};
    vt[3]  = '{"jz_nz",     16'h2005, 5'd3,  1'b0, 1'b0, 5'd0,  1'b0, 16'h0000};
    vt[4]  = '{"jz_z",      16'h2005, 5'd3,  1'b1, 1'b1, 5'd5,  1'b0, 16'h0000};
    vt[5]  = '{"jnz_nz",    16'h3007, 5'd4,  1'b0, 1'b1, 5'd7,  1'b0, 16'h0000};
    vt[6]  = '{"jnz_z",     16'h3007, 5'd4,  1'b1, 1'b0, 5'd0,  1'b0, 16'h0000};
    vt[7]  = '{"exec_a123", 16'hA123, 5'd5,  1'b0, 1'b0, 5'd0,  1'b1, 16'hA123};
    vt[8]  = '{"exec_8000", 16'h8000, 5'd6,  1'b1, 1'b0, 5'd0,  1'b1, 16'h8000};
    vt[9]  = '{"wait0",     16'h6000, 5'd7,  1'b0, 1'b0, 5'd0,  1'b0, 16'h0000};
    vt[10] = '{"wait0_hi",  16'h6300, 5'd8,  1'b0, 1'b0, 5'd0,  1'b0, 16'h0000};

    // Reset held 3 cycles: outputs zero even with active-looking words.
    apply(1'b0, 16'h0000, 5'd0, 1'b0); chk_all_zero("rst_nop");
    apply(1'b0, 16'h100C, 5'd1, 1'b0); chk_all_zero("rst_jmp");
    apply(1'b0, 16'hA123, 5'd2, 1'b0); chk_all_zero("rst_exec");
    apply(1'b1, 16'h0000, 5'd0, 1'b0); chk_jump("post_rst_nop", 1'b0, 5'd0);

    foreach (vt[i]) begin
      apply(1'b1, vt[i].word, vt[i].pc, vt[i].cz);
      chk_jump(vt[i].name, vt[i].jen, vt[i].jval);
      chk({vt[i].name, ".ev"}, 32'(exec_valid), 32'(vt[i].ev));
      chk({vt[i].name, ".ew"}, 32'(exec_word),  32'(vt[i].ew));
    end
    // The two WAIT 0 vectors must not have left the FSM waiting.
    apply(1'b1, 16'h100C, 5'd9, 1'b0); chk_jump("after_wait0", 1'b1, 5'd12);
    chk("no_fault_yet", 32'(fault), 32'd0);

    // RET on an empty stack.
    apply(1'b1, 16'h5000, 5'd2, 1'b0); chk_jump("ret_empty", 1'b0, 5'd0);
    chk("ret_empty.fault_same", 32'(fault), 32'd0);
    apply(1'b1, 16'h0000, 5'd3, 1'b0); chk("ret_empty.fault", 32'(fault), 32'd1);
    apply(1'b1, 16'h0000, 5'd4, 1'b0); chk("fault_sticky", 32'(fault), 32'd1);
    do_reset(); chk("fault_rst", 32'(fault), 32'd0);

    // Nested calls and returns.
    apply(1'b1, 16'h4008, 5'd3,  1'b0); chk_jump("call8",  1'b1, 5'd8);
    apply(1'b1, 16'h4010, 5'd9,  1'b0); chk_jump("call16", 1'b1, 5'd16);
    apply(1'b1, 16'h5000, 5'd16, 1'b0); chk_jump("ret1",   1'b1, 5'd10);
    apply(1'b1, 16'h5000, 5'd11, 1'b0); chk_jump("ret2",   1'b1, 5'd4);
    chk("nest.fault", 32'(fault), 32'd0);

    // Five nested calls into a depth-4 stack.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 16'h4000 | 16'(k + 1), 5'(k), 1'b0);
      chk_jump($sformatf("deep_call%0d", k), 1'b1, 5'(k + 1));
    end
    apply(1'b1, 16'h401E, 5'd4, 1'b0); chk_jump("call_full", 1'b0, 5'd0);
    apply(1'b1, 16'h5000, 5'd5, 1'b0); chk_jump("ret_after_full", 1'b1, 5'd4);
    chk("call_full.fault", 32'(fault), 32'd1);

    // CALL at the last address pushes 0.
    do_reset();
    apply(1'b1, 16'h4005, 5'd31, 1'b0); chk_jump("call_wrap", 1'b1, 5'd5);
    apply(1'b1, 16'h5000, 5'd5,  1'b0); chk_jump("ret_wrap",  1'b1, 5'd0);

    // WAIT 3 at 7; the held address shows a different word, which must be ignored.
    apply(1'b1, 16'h6003, 5'd7, 1'b0); chk_jump("wait_c1", 1'b1, 5'd7);
    apply(1'b1, 16'h101F, 5'd7, 1'b0); chk_jump("wait_c2", 1'b1, 5'd7);
    apply(1'b1, 16'hA123, 5'd7, 1'b0); chk_jump("wait_c3", 1'b1, 5'd7);
    chk("wait_c3.ev", 32'(exec_valid), 32'd0);
    apply(1'b1, 16'h101F, 5'd7, 1'b0); chk_jump("wait_c4", 1'b0, 5'd0);
    apply(1'b1, 16'h100C, 5'd8, 1'b0); chk_jump("wait_done", 1'b1, 5'd12);

    // Reset during the second WAIT cycle abandons the wait.
    apply(1'b1, 16'h6003, 5'd7, 1'b0); chk_jump("wrst_c1", 1'b1, 5'd7);
    apply(1'b0, 16'h6003, 5'd7, 1'b0); chk_all_zero("wrst_c2");
    apply(1'b1, 16'h100C, 5'd7, 1'b0); chk_jump("wrst_run", 1'b1, 5'd12);

    // HALT at 20.
    apply(1'b1, 16'h7000, 5'd20, 1'b0); chk_jump("halt_c0", 1'b1, 5'd20);
    chk("halt_c0.halted", 32'(halted), 32'd0);
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 16'hA123, 5'd20, 1'b1);
      chk_jump($sformatf("halt_c%0d", k + 1), 1'b1, 5'd20);
      chk($sformatf("halt_c%0d.halted", k + 1), 32'(halted), 32'd1);
      chk($sformatf("halt_c%0d.ev", k + 1), 32'(exec_valid), 32'd0);
    end
    apply(1'b0, 16'h7000, 5'd20, 1'b0); chk_all_zero("halt_rst");
    apply(1'b1, 16'h0000, 5'd0,  1'b0); chk_jump("halt_exit", 1'b0, 5'd0);
    chk("halt_exit.halted", 32'(halted), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
